stream_deserializer: RTL

//   Consumer end of a valid/yumi stream.
//   - Drains width_p-bit elements from an upstream valid/yumi producer by

---
 rtl/stream_deserializer.sv | 73 +++++++
 1 files changed

// File: rtl/stream_deserializer.sv
// Packs els_p consecutive valid/yumi elements (lane 0 first) into one wide valid/ready word.
// Optional STREAM_DESERIALIZER_FLUSH_EN adds flush_i/count_o to close a partial word early.
module stream_deserializer #(
  parameter int width_p = 10,
  parameter int els_p   = 4,
  localparam int cnt_w  = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
`ifdef STREAM_DESERIALIZER_FLUSH_EN
  input  logic                       flush_i,
  output logic [cnt_w-1:0]           count_o,
`endif
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  output logic                       valid_o,
  output logic [width_p*els_p-1:0]   data_o,
  input  logic                       ready_i
);

  // Handshake: an element moves when yumi_o=1 (yumi_o implies valid_i);
  // a word moves when valid_o & ready_i. valid_o is a pure register.
  logic [els_p-1:0][width_p-1:0] lanes_q, lanes_d;
  logic [cnt_w-1:0]              count_q, count_d, wr_idx;
  logic                          closed_q, closed_d;
  logic                          hs, full, flush_close;

  always_comb begin
    hs          = closed_q & ready_i;
    yumi_o      = reset_n_i & valid_i & (~closed_q | ready_i);
    wr_idx      = hs ? '0 : count_q;
    count_d     = count_q;
    flush_close = 1'b0;

    if (hs && yumi_o)  count_d = cnt_w'(1);
    else if (hs)       count_d = '0;
    else if (yumi_o)   count_d = count_q + cnt_w'(1);

    full = (count_d == cnt_w'(els_p));
`ifdef STREAM_DESERIALIZER_FLUSH_EN
    // Flush only closes a word that will hold at least one element.
    flush_close = flush_i & ~closed_q & ((count_q != '0) | yumi_o);
`endif
    closed_d = (closed_q & ~hs) | full | flush_close;

    // After a handoff every lane not refilled this cycle reads back as 0.
    for (int k = 0; k < els_p; k++) begin
      lanes_d[k] = lanes_q[k];
      if (yumi_o && (wr_idx == cnt_w'(k))) lanes_d[k] = data_i;
      else if (hs)                         lanes_d[k] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lanes_q  <= '0;
      count_q  <= '0;
      closed_q <= 1'b0;
    end else begin
      lanes_q  <= lanes_d;
      count_q  <= count_d;
      closed_q <= closed_d;
    end
  end

  assign valid_o = closed_q;
  assign data_o  = lanes_q;
`ifdef STREAM_DESERIALIZER_FLUSH_EN
  assign count_o = count_q;
`endif

endmodule
